// File: rtl/fetch_pkg.sv
// Shared widths, decode/fetch widths and the queue entry type for the fetch front end.
package fetch_pkg;
  localparam int PC_WIDTH     = 32;
  localparam int REG_WIDTH    = 32;
  localparam int FETCH_WIDTH  = 4;
  localparam int DECODE_WIDTH = 2;

  typedef logic [PC_WIDTH-1:0]  pc_t;
  typedef logic [REG_WIDTH-1:0] inst_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue: 0..4 pushes and 0..2 pops per cycle, single-cycle flush.
module inst_queue
  import fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  localparam int AW = $clog2(QUEUE_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_flush,
  input  logic [2:0]                          i_push_n,
  input  fetch_entry_t [FETCH_WIDTH-1:0]      i_push_entry,
  input  logic [1:0]                          i_pop_n,
  output logic [CW-1:0]                       o_count,
  output fetch_entry_t [DECODE_WIDTH-1:0]     o_head_entry
);

  fetch_entry_t  r_mem [QUEUE_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(i_pop_n);
      r_tail  <= r_tail + AW'(i_push_n);
      r_count <= r_count + CW'(i_push_n) - CW'(i_pop_n);
    end
  end

  // Entry storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (!i_flush) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (i < int'(i_push_n)) r_mem[r_tail + AW'(i)] <= i_push_entry[i];
      end
    end
  end

  always_comb begin
    o_head_entry = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      o_head_entry[k] = r_mem[r_head + AW'(k)];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch engine: drives the icache PC, enqueues up to four words per cycle and
// presents up to two (inst, pc) pairs to decode; redirects flush and restart.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int  QUEUE_DEPTH = 8,
  parameter pc_t RESET_PC    = 32'h0000_0000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output pc_t                                    icache_pc,
  input  logic [FETCH_WIDTH-1:0][REG_WIDTH-1:0]  icache_inst,
  input  logic                                   redirect_valid,
  input  pc_t                                    redirect_pc,
  input  logic [1:0]                             deq_count,
  output logic [1:0]                             out_count,
  output logic [DECODE_WIDTH-1:0][REG_WIDTH-1:0] out_inst,
  output logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0]  out_pc
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = CW + 1;

  pc_t                               r_fetch_pc;
  pc_t                               w_redirect_base;
  logic [CW-1:0]                     w_count;
  logic [FW-1:0]                     w_free;
  logic [2:0]                        w_push_n;
  fetch_entry_t [FETCH_WIDTH-1:0]    w_push_entry;
  fetch_entry_t [DECODE_WIDTH-1:0]   w_head;

  // Space freed by this cycle's pop is reusable by this cycle's push.
  assign w_free   = FW'(QUEUE_DEPTH) - FW'(w_count) + FW'(deq_count);
  assign w_push_n = redirect_valid                  ? 3'd0 :
                    (w_free >= FW'(FETCH_WIDTH))    ? 3'(FETCH_WIDTH) :
                                                      w_free[2:0];
  assign w_redirect_base = redirect_pc & ~pc_t'(3);

  always_comb begin
    w_push_entry = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_push_entry[i].pc   = r_fetch_pc + pc_t'(4 * i);
      w_push_entry[i].inst = icache_inst[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_fetch_pc <= RESET_PC;
    else if (redirect_valid) r_fetch_pc <= w_redirect_base;
    else                     r_fetch_pc <= r_fetch_pc + pc_t'({w_push_n, 2'b00});
  end

  inst_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (redirect_valid),
    .i_push_n     (w_push_n),
    .i_push_entry (w_push_entry),
    .i_pop_n      (deq_count),
    .o_count      (w_count),
    .o_head_entry (w_head)
  );

  assign icache_pc = r_fetch_pc;

  always_comb begin
    out_count = (w_count >= CW'(2)) ? 2'd2 : w_count[1:0];
    out_inst  = '0;
    out_pc    = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      if (k < int'(out_count)) begin
        out_inst[k] = w_head[k].inst;
        out_pc[k]   = w_head[k].pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: icache model returns word = address; a second
// instance with RESET_PC near the top of the address space checks PC wrap.
module tb_fetch_unit;

  logic              clk = 1'b0;
  logic              rst = 1'b1;

  logic [31:0]       ipc1, ipc2;
  logic [3:0][31:0]  ic1, ic2;
  logic              rv1, rv2;
  logic [31:0]       rpc1, rpc2;
  logic [1:0]        deq1, deq2;
  logic [1:0]        cnt1, cnt2;
  logic [1:0][31:0]  oi1, oi2, op1, op2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.QUEUE_DEPTH(8), .RESET_PC(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst), .icache_pc(ipc1), .icache_inst(ic1),
    .redirect_valid(rv1), .redirect_pc(rpc1), .deq_count(deq1),
    .out_count(cnt1), .out_inst(oi1), .out_pc(op1)
  );

  fetch_unit #(.QUEUE_DEPTH(8), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .icache_pc(ipc2), .icache_inst(ic2),
    .redirect_valid(rv2), .redirect_pc(rpc2), .deq_count(deq2),
    .out_count(cnt2), .out_inst(oi2), .out_pc(op2)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ic1[i] = ipc1 + 32'(4 * i);
      ic2[i] = ipc2 + 32'(4 * i);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (deq1 <= cnt1) else $error("illegal deq_count %0d > out_count %0d (dut1)", deq1, cnt1);
      assert (deq2 <= cnt2) else $error("illegal deq_count %0d > out_count %0d (dut2)", deq2, cnt2);
    end
  end

  typedef struct {
    logic [1:0]  deq;
    logic        rv;
    logic [31:0] rpc;
    logic [1:0]  cnt;
    logic [31:0] ipc;
    logic [31:0] pc0;
  } vec_t;

  vec_t tv [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic chk_dut1(input string tag, input logic [1:0] ecnt, input logic [31:0] eipc,
                          input logic [31:0] epc0);
    chk({tag, " out_count"}, 32'(cnt1), 32'(ecnt));
    chk({tag, " icache_pc"}, ipc1, eipc);
    if (ecnt == 2'd2) begin
      chk({tag, " out_pc0"},   op1[0], epc0);
      chk({tag, " out_pc1"},   op1[1], epc0 + 32'd4);
      chk({tag, " out_inst0"}, oi1[0], epc0);
      chk({tag, " out_inst1"}, oi1[1], epc0 + 32'd4);
    end else begin
      chk({tag, " out_pc0 zero"},   op1[0], 32'h0);
      chk({tag, " out_pc1 zero"},   op1[1], 32'h0);
      chk({tag, " out_inst0 zero"}, oi1[0], 32'h0);
      chk({tag, " out_inst1 zero"}, oi1[1], 32'h0);
    end
  endtask

  initial begin
    //           deq   rv    rpc            cnt   icache_pc      out_pc0
    tv[0]  = '{2'd0, 1'b0, 32'h0,        2'd0, 32'h0000_0000, 32'h0};
    tv[1]  = '{2'd0, 1'b0, 32'h0,        2'd2, 32'h0000_0010, 32'h0000_0000};
    tv[2]  = '{2'd0, 1'b0, 32'h0,        2'd2, 32'h0000_0020, 32'h0000_0000};
    tv[3]  = '{2'd2, 1'b0, 32'h0,        2'd2, 32'h0000_0020, 32'h0000_0000};
    tv[4]  = '{2'd2, 1'b0, 32'h0,        2'd2, 32'h0000_0028, 32'h0000_0008};
    tv[5]  = '{2'd2, 1'b0, 32'h0,        2'd2, 32'h0000_0030, 32'h0000_0010};
    tv[6]  = '{2'd2, 1'b0, 32'h0,        2'd2, 32'h0000_0038, 32'h0000_0018};
    tv[7]  = '{2'd2, 1'b0, 32'h0,        2'd2, 32'h0000_0040, 32'h0000_0020};
    tv[8]  = '{2'd2, 1'b1, 32'h0000_0102, 2'd2, 32'h0000_0048, 32'h0000_0028};
    tv[9]  = '{2'd0, 1'b0, 32'h0,        2'd0, 32'h0000_0100, 32'h0};
    tv[10] = '{2'd2, 1'b0, 32'h0,        2'd2, 32'h0000_0110, 32'h0000_0100};
    tv[11] = '{2'd0, 1'b0, 32'h0,        2'd2, 32'h0000_0120, 32'h0000_0108};
    tv[12] = '{2'd0, 1'b0, 32'h0,        2'd2, 32'h0000_0128, 32'h0000_0108};
    tv[13] = '{2'd0, 1'b1, 32'h0000_0200, 2'd2, 32'h0000_0128, 32'h0000_0108};
    tv[14] = '{2'd0, 1'b0, 32'h0,        2'd0, 32'h0000_0200, 32'h0};
    tv[15] = '{2'd2, 1'b0, 32'h0,        2'd2, 32'h0000_0210, 32'h0000_0200};
    tv[16] = '{2'd1, 1'b0, 32'h0,        2'd2, 32'h0000_0220, 32'h0000_0208};
    tv[17] = '{2'd0, 1'b0, 32'h0,        2'd2, 32'h0000_022C, 32'h0000_020C};
    tv[18] = '{2'd2, 1'b0, 32'h0,        2'd2, 32'h0000_022C, 32'h0000_020C};
    tv[19] = '{2'd0, 1'b0, 32'h0,        2'd2, 32'h0000_0234, 32'h0000_0214};

    rv1 = 1'b0; rpc1 = '0; deq1 = '0;
    rv2 = 1'b0; rpc2 = '0; deq2 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("dut2 reset out_count", 32'(cnt2), 32'd0);
    chk("dut2 reset icache_pc", ipc2, 32'hFFFF_FFF8);
    chk("dut2 reset out_pc0",   op2[0], 32'h0);

    for (int v = 0; v < 20; v++) begin
      chk_dut1($sformatf("vec%0d", v), tv[v].cnt, tv[v].ipc, tv[v].pc0);
      deq1 = tv[v].deq;
      rv1  = tv[v].rv;
      rpc1 = tv[v].rpc;
      @(negedge clk);
    end
    deq1 = 2'd0; rv1 = 1'b0;

    // dut2 sat full since reset; draining 2 per cycle walks the PC through zero
    // and wraps the queue pointers.
    for (int k = 0; k < 6; k++) begin
      logic [31:0] epc;
      epc = 32'hFFFF_FFF8 + 32'(8 * k);
      chk($sformatf("wrap%0d out_count", k), 32'(cnt2), 32'd2);
      chk($sformatf("wrap%0d out_pc0", k),   op2[0], epc);
      chk($sformatf("wrap%0d out_pc1", k),   op2[1], epc + 32'd4);
      chk($sformatf("wrap%0d out_inst0", k), oi2[0], epc);
      chk($sformatf("wrap%0d icache_pc", k), ipc2, 32'h0000_0018 + 32'(8 * k));
      deq2 = 2'd2;
      @(negedge clk);
    end
    deq2 = 2'd0;

    // Asynchronous reset between clock edges while a burst is in flight.
    rv1 = 1'b1; rpc1 = 32'h0000_0300;
    @(negedge clk);
    rv1 = 1'b0;
    @(negedge clk);
    chk_dut1("pre-arst", 2'd2, 32'h0000_0310, 32'h0000_0300);
    #2 rst = 1'b1;
    #1;
    chk("arst out_count",      32'(cnt1), 32'd0);
    chk("arst icache_pc",      ipc1, 32'h0000_0000);
    chk("arst out_pc0",        op1[0], 32'h0);
    chk("arst dut2 icache_pc", ipc2, 32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b0;
    chk_dut1("post-arst idle", 2'd0, 32'h0000_0000, 32'h0);
    @(negedge clk);
    chk_dut1("post-arst resume", 2'd2, 32'h0000_0010, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
